// File: rtl/spart_pkg.sv
// Shared constants and state types for the SPART memory-mapped UART.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int TBR_BIT = 0;
    localparam int RDA_BIT = 1;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK   = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud divisor registers and the 16x oversample tick down-counter.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wr_data,
    output logic [15:0] div,
    output logic        tick
);

    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;

    // A divisor write only takes effect at the next reload, never mid-count.
    always_comb begin
        div_d = div_q;
        if (wr_lo) div_d[7:0]  = wr_data;
        if (wr_hi) div_d[15:8] = wr_data;
        tick  = (cnt_q == 16'd0);
        cnt_d = tick ? div_q : cnt_q - 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DEFAULT_DIV;
            cnt_q <= DEFAULT_DIV;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign div = div_q;

endmodule

// File: rtl/spart_uart.sv
// Memory-mapped UART: bus decode, RX/TX state machines and status flags.
module spart_uart
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        rd_en, wr_en, tick, rx_done;
    logic [15:0] div;
    logic [7:0]  rd_data, status;
    logic        rxd_meta_q, rxd_sync_q;

    rx_state_t   rx_state_q, rx_state_d;
    logic [3:0]  rx_tick_cnt_q, rx_tick_cnt_d;
    logic [2:0]  rx_bit_cnt_q, rx_bit_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic        rda_q, rda_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  tx_tick_cnt_q, tx_tick_cnt_d;
    logic [3:0]  tx_bit_cnt_q, tx_bit_cnt_d;
    logic        tbr_q, tbr_d;
    logic        txd_q, txd_d;

    assign rd_en = iocs & iorw;
    assign wr_en = iocs & ~iorw;

    spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_lo  (wr_en && ioaddr == ADDR_DB_LO),
        .wr_hi  (wr_en && ioaddr == ADDR_DB_HI),
        .wr_data(databus),
        .div    (div),
        .tick   (tick)
    );

    always_comb begin
        status          = 8'h00;
        status[TBR_BIT] = tbr_q;
        status[RDA_BIT] = rda_q;
        case (ioaddr)
            ADDR_DATA:   rd_data = rx_buf_q;
            ADDR_STATUS: rd_data = status;
            ADDR_DB_LO:  rd_data = div[7:0];
            default:     rd_data = div[15:8];
        endcase
    end

    assign databus = rd_en ? rd_data : 8'bz;

    // Start bit is confirmed at mid-bit, so every later sample lands mid-bit too.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tick_cnt_d = rx_tick_cnt_q;
        rx_bit_cnt_d  = rx_bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_done       = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxd_sync_q) begin
                    rx_state_d    = RX_START;
                    rx_tick_cnt_d = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    rx_tick_cnt_d = rx_tick_cnt_q + 4'd1;
                    if (rx_tick_cnt_q == MID_TICK) begin
                        rx_tick_cnt_d = 4'd0;
                        rx_bit_cnt_d  = 3'd0;
                        rx_state_d    = rxd_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tick_cnt_d = rx_tick_cnt_q + 4'd1;
                    if (rx_tick_cnt_q == LAST_TICK) begin
                        rx_shift_d   = {rxd_sync_q, rx_shift_q[7:1]};
                        rx_bit_cnt_d = rx_bit_cnt_q + 3'd1;
                        if (rx_bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tick_cnt_d = rx_tick_cnt_q + 4'd1;
                    if (rx_tick_cnt_q == LAST_TICK) begin
                        rx_state_d = RX_IDLE;
                        rx_done    = rxd_sync_q;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A completing byte beats a same-cycle data read, so rda ends up set.
    always_comb begin
        rda_d    = rda_q;
        rx_buf_d = rx_buf_q;
        if (rd_en && ioaddr == ADDR_DATA) rda_d = 1'b0;
        if (rx_done) begin
            rda_d    = 1'b1;
            rx_buf_d = rx_shift_q;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_shift_d    = tx_shift_q;
        tx_tick_cnt_d = tx_tick_cnt_q;
        tx_bit_cnt_d  = tx_bit_cnt_q;
        tbr_d         = tbr_q;
        txd_d         = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_en && ioaddr == ADDR_DATA && tbr_q) begin
                    tx_shift_d    = {1'b1, databus, 1'b0};
                    txd_d         = 1'b0;
                    tbr_d         = 1'b0;
                    tx_tick_cnt_d = 4'd0;
                    tx_bit_cnt_d  = 4'd0;
                    tx_state_d    = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tick) begin
                    tx_tick_cnt_d = tx_tick_cnt_q + 4'd1;
                    if (tx_tick_cnt_q == LAST_TICK) begin
                        if (tx_bit_cnt_q == 4'd9) begin
                            tx_state_d = TX_IDLE;
                            tbr_d      = 1'b1;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_cnt_d = tx_bit_cnt_q + 4'd1;
                            tx_shift_d   = {1'b1, tx_shift_q[9:1]};
                            txd_d        = tx_shift_q[1];
                        end
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q    <= 1'b1;
            rxd_sync_q    <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_tick_cnt_q <= 4'd0;
            rx_bit_cnt_q  <= 3'd0;
            rx_shift_q    <= 8'h00;
            rx_buf_q      <= 8'h00;
            rda_q         <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_shift_q    <= 10'h3FF;
            tx_tick_cnt_q <= 4'd0;
            tx_bit_cnt_q  <= 4'd0;
            tbr_q         <= 1'b1;
            txd_q         <= 1'b1;
        end else begin
            rxd_meta_q    <= rxd;
            rxd_sync_q    <= rxd_meta_q;
            rx_state_q    <= rx_state_d;
            rx_tick_cnt_q <= rx_tick_cnt_d;
            rx_bit_cnt_q  <= rx_bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_buf_q      <= rx_buf_d;
            rda_q         <= rda_d;
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            tx_tick_cnt_q <= tx_tick_cnt_d;
            tx_bit_cnt_q  <= tx_bit_cnt_d;
            tbr_q         <= tbr_d;
            txd_q         <= txd_d;
        end
    end

    assign rda = rda_q;
    assign tbr = tbr_q;
    assign txd = txd_q;

endmodule
